// File: rtl/cq_viola_nios2_oci_dct_packer.sv
// Debug-capture-trace packer: gathers narrow trace items into wide words,
// queues finished words in a small shift FIFO and flushes on test end.
module cq_viola_nios2_oci_dct_packer #(
   parameter int unsigned ITEM_W     = 2,
   parameter int unsigned SLOTS      = 15,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned OVF_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          item_valid,
   input  logic [ITEM_W-1:0]             item_data,
   input  logic                          test_ending,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ITEM_W*SLOTS-1:0]       out_buffer,
   output logic [CNT_W-1:0]              out_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [OVF_W-1:0]              ovf_count,
   output logic                          test_has_ended
);

   localparam int unsigned BUF_W = ITEM_W * SLOTS;
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ENDED = 2'd2
   } state_t;

   state_t           state;
   logic             te_q;

   logic [BUF_W-1:0] pk_buf;
   logic [CNT_W-1:0] pk_cnt;
   logic [BUF_W-1:0] buf_after;
   logic [CNT_W-1:0] cnt_after;

   logic [BUF_W-1:0] mem_buf [FIFO_DEPTH];
   logic [CNT_W-1:0] mem_cnt [FIFO_DEPTH];
   logic [BUF_W-1:0] nxt_buf [FIFO_DEPTH];
   logic [CNT_W-1:0] nxt_cnt [FIFO_DEPTH];

   logic [LVL_W-1:0] wr_idx;
   logic [LVL_W-1:0] level_nxt;

   logic             running;
   logic             accept;
   logic             flush;
   logic             commit;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   // Entry 0 of the shift FIFO is always the head word.
   assign out_buffer = mem_buf[0];
   assign out_count  = mem_cnt[0];

   // Packing and commit decision; an item arriving with the flush edge is included first.
   always_comb begin
      running   = (state == RUN);
      accept    = running & item_valid;
      flush     = running & test_ending & ~te_q;
      cnt_after = pk_cnt + CNT_W'(accept);
      buf_after = pk_buf;
      for (int unsigned k = 0; k < SLOTS; k++) begin
         if (accept && (pk_cnt == CNT_W'(k))) begin
            buf_after[k*ITEM_W +: ITEM_W] = item_data;
         end
      end
      commit    = running & ((cnt_after == CNT_W'(SLOTS)) | (flush & (cnt_after != '0)));
      full      = (fifo_level == LVL_W'(FIFO_DEPTH));
      pop       = out_valid & out_ready;
      push      = commit & (~full | pop);
      drop      = commit & full & ~pop;
      wr_idx    = fifo_level - LVL_W'(pop);
      level_nxt = fifo_level + LVL_W'(push) - LVL_W'(pop);
   end

   // Next FIFO contents: shift on pop, then write the new tail slot.
   always_comb begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         nxt_buf[i] = mem_buf[i];
         nxt_cnt[i] = mem_cnt[i];
      end
      if (pop) begin
         for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
            nxt_buf[i] = mem_buf[i+1];
            nxt_cnt[i] = mem_cnt[i+1];
         end
         nxt_buf[FIFO_DEPTH-1] = '0;
         nxt_cnt[FIFO_DEPTH-1] = '0;
      end
      if (push) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_idx == LVL_W'(i)) begin
               nxt_buf[i] = buf_after;
               nxt_cnt[i] = cnt_after;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_buf[i] <= '0;
            mem_cnt[i] <= '0;
         end
         fifo_level <= '0;
         out_valid  <= 1'b0;
         ovf_count  <= '0;
      end else begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_buf[i] <= nxt_buf[i];
            mem_cnt[i] <= nxt_cnt[i];
         end
         fifo_level <= level_nxt;
         out_valid  <= (level_nxt != '0);
         if (drop && (ovf_count != '1)) begin
            ovf_count <= ovf_count + OVF_W'(1);
         end
      end
   end

   // Pack buffer is cleared on every commit, including dropped ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pk_buf <= '0;
         pk_cnt <= '0;
         te_q   <= 1'b0;
      end else begin
         te_q <= test_ending;
         if (commit) begin
            pk_buf <= '0;
            pk_cnt <= '0;
         end else if (accept) begin
            pk_buf <= buf_after;
            pk_cnt <= cnt_after;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RUN;
         test_has_ended <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (flush) state <= DRAIN;
            end
            DRAIN: begin
               if (fifo_level == '0) state <= ENDED;
            end
            ENDED: begin
               test_has_ended <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cq_viola_nios2_oci_dct_packer.sv
// Self-checking bench for the DCT packer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cq_viola_nios2_oci_dct_packer;

   localparam int ITEM_W     = 2;
   localparam int SLOTS      = 15;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 4;
   localparam int OVF_W      = 16;
   localparam int BUF_W      = ITEM_W * SLOTS;
   localparam int LVL_W      = 3;
   localparam int OVF_MAX    = (1 << OVF_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              item_valid;
   logic [ITEM_W-1:0] item_data;
   logic              test_ending;
   logic              out_valid;
   logic              out_ready;
   logic [BUF_W-1:0]  out_buffer;
   logic [CNT_W-1:0]  out_count;
   logic [LVL_W-1:0]  fifo_level;
   logic [OVF_W-1:0]  ovf_count;
   logic              test_has_ended;

   int checks   = 0;
   int failures = 0;

   cq_viola_nios2_oci_dct_packer #(
      .ITEM_W(ITEM_W), .SLOTS(SLOTS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .OVF_W(OVF_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .item_valid(item_valid), .item_data(item_data),
      .test_ending(test_ending), .out_valid(out_valid), .out_ready(out_ready),
      .out_buffer(out_buffer), .out_count(out_count), .fifo_level(fifo_level),
      .ovf_count(ovf_count), .test_has_ended(test_has_ended)
   );

   always #5 clk = ~clk;

   // Reference model: items of the open word, queued words, phase 0=run 1=drain 2=ended.
   typedef struct { logic [BUF_W-1:0] b; int c; } word_t;
   word_t mq[$];
   int    pend[$];
   int    m_ovf;
   int    m_phase;
   bit    m_te_prev;
   bit    m_ended;

   typedef struct {
      bit iv; int d; bit te; bit rdy;
      int e_valid; int e_lvl; int e_cnt; int e_buf; int e_ovf; int e_ended;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int item_of(int i);
      return (i / SLOTS + i % SLOTS) % 4;
   endfunction

   function automatic logic [BUF_W-1:0] exp_word(int w, int n);
      logic [BUF_W-1:0] b;
      b = '0;
      for (int k = 0; k < n; k++) b[k*ITEM_W +: ITEM_W] = ITEM_W'(item_of(w * SLOTS + k));
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      pend.delete();
      m_ovf = 0; m_phase = 0; m_te_prev = 0; m_ended = 0;
   endtask

   task automatic model_step(bit iv, int d, bit te, bit rdy);
      bit pop, flush, commit, full;
      word_t w;
      pop    = (mq.size() != 0) && rdy;
      flush  = te && !m_te_prev && (m_phase == 0);
      commit = 0;
      w.b = '0; w.c = 0;
      if (m_phase == 0 && iv) pend.push_back(d);
      if (m_phase == 0 && (pend.size() == SLOTS || (flush && pend.size() > 0))) commit = 1;
      if (m_phase == 2) m_ended = 1;
      if (m_phase == 1 && mq.size() == 0) m_phase = 2;
      else if (flush) m_phase = 1;
      if (commit) begin
         w.c = pend.size();
         foreach (pend[k]) w.b[k*ITEM_W +: ITEM_W] = ITEM_W'(pend[k]);
         pend.delete();
      end
      full = (mq.size() == FIFO_DEPTH);
      if (pop) void'(mq.pop_front());
      if (commit) begin
         if (!full || pop) mq.push_back(w);
         else if (m_ovf < OVF_MAX) m_ovf++;
      end
      m_te_prev = te;
   endtask

   task automatic check_model();
      chk("level", fifo_level, mq.size());
      chk("valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("head_buf", out_buffer, mq[0].b);
         chk("head_cnt", out_count, mq[0].c);
      end
      chk("ovf", ovf_count, m_ovf);
      chk("ended", test_has_ended, m_ended);
   endtask

   task automatic step(bit iv, int d, bit te, bit rdy);
      item_valid = iv; item_data = ITEM_W'(d); test_ending = te; out_ready = rdy;
      @(posedge clk);
      #1;
      model_step(iv, d, te, rdy);
      check_model();
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_level"}, fifo_level, 0);
      chk({tag, "_buf"}, out_buffer, 0);
      chk({tag, "_cnt"}, out_count, 0);
      chk({tag, "_ovf"}, ovf_count, 0);
      chk({tag, "_ended"}, test_has_ended, 0);
   endtask

   task automatic do_reset();
      item_valid = 0; item_data = '0; test_ending = 0; out_ready = 0;
      reset_n = 0;
      @(posedge clk);
      #1;
      check_zero("reset");
      reset_n = 1;
      model_reset();
   endtask

   task automatic feed(int first, int n, bit rdy);
      for (int i = first; i < first + n; i++) step(1, item_of(i), 0, rdy);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1, 1, 0, 1, 0, 0, 0, 0,  0, 0};
      tbl[1] = '{1, 2, 0, 1, 0, 0, 0, 0,  0, 0};
      tbl[2] = '{1, 3, 1, 1, 1, 1, 3, 57, 0, 0};
      tbl[3] = '{1, 0, 1, 1, 0, 0, 0, 0,  0, 0};
      tbl[4] = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0};
      tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 1};
      tbl[6] = '{1, 2, 1, 1, 0, 0, 0, 0,  0, 1};

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].te, tbl[i].rdy);
         chk("tbl_valid", out_valid, tbl[i].e_valid);
         chk("tbl_level", fifo_level, tbl[i].e_lvl);
         if (tbl[i].e_valid != 0) begin
            chk("tbl_cnt", out_count, tbl[i].e_cnt);
            chk("tbl_buf", out_buffer, tbl[i].e_buf);
         end
         chk("tbl_ovf", ovf_count, tbl[i].e_ovf);
         chk("tbl_ended", test_has_ended, tbl[i].e_ended);
      end

      // Full word appears one cycle after its 15th item.
      do_reset();
      feed(0, SLOTS - 1, 1);
      chk("t1_not_yet", out_valid, 0);
      feed(SLOTS - 1, 1, 1);
      chk("t1_valid", out_valid, 1);
      chk("t1_cnt", out_count, SLOTS);
      chk("t1_buf", out_buffer, exp_word(0, SLOTS));

      // Partial flush of 5 items, then completion and ignored input.
      do_reset();
      feed(0, 5, 1);
      step(0, 0, 1, 0);
      chk("t2_cnt", out_count, 5);
      chk("t2_buf", out_buffer, exp_word(0, 5));
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("t2_ended_early", test_has_ended, 0);
      step(0, 0, 0, 1);
      chk("t2_ended", test_has_ended, 1);
      feed(0, SLOTS, 1);
      chk("t2_ignored", fifo_level, 0);

      // Backpressure: six words into four slots.
      do_reset();
      feed(0, 6 * SLOTS, 0);
      chk("t3_level", fifo_level, 4);
      chk("t3_ovf", ovf_count, 2);
      for (int j = 0; j < 4; j++) begin
         chk("t3_order", out_buffer, exp_word(j, SLOTS));
         step(0, 0, 0, 1);
      end
      chk("t3_empty", fifo_level, 0);

      // 15th item on the flush edge: a single full word.
      do_reset();
      feed(0, SLOTS - 1, 1);
      step(1, item_of(SLOTS - 1), 1, 1);
      chk("t4_level", fifo_level, 1);
      chk("t4_cnt", out_count, SLOTS);
      chk("t4_buf", out_buffer, exp_word(0, SLOTS));
      for (int j = 0; j < 3; j++) step(0, 0, 0, 1);
      chk("t4_ended", test_has_ended, 1);
      chk("t4_level_end", fifo_level, 0);

      // Commit into a full FIFO while it pops.
      do_reset();
      feed(0, 4 * SLOTS + SLOTS - 1, 0);
      chk("t5_full", fifo_level, 4);
      step(1, item_of(5 * SLOTS - 1), 0, 1);
      chk("t5_level", fifo_level, 4);
      chk("t5_ovf", ovf_count, 0);
      chk("t5_head", out_buffer, exp_word(1, SLOTS));

      // Empty flush: ended exactly two cycles after the edge.
      do_reset();
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk("t7_ended_1", test_has_ended, 0);
      step(0, 0, 0, 1);
      chk("t7_ended_2", test_has_ended, 1);

      // Asynchronous reset in DRAIN with three words queued.
      do_reset();
      feed(0, 3 * SLOTS, 0);
      step(0, 0, 1, 0);
      chk("t6_level", fifo_level, 3);
      #2;
      reset_n = 0;
      #1;
      check_zero("t6_async");
      @(posedge clk);
      #1;
      reset_n = 1;
      model_reset();
      test_ending = 0;
      feed(0, SLOTS, 1);
      chk("t6_run_valid", out_valid, 1);
      chk("t6_run_cnt", out_count, SLOTS);

      // Randomized traffic with varying sink stall rates and test_ending glitches.
      for (int r = 0; r < 8; r++) begin
         int te_at;
         do_reset();
         te_at = 100 + int'($urandom_range(0, 250));
         for (int c = 0; c < 400; c++) begin
            bit iv, te, rdy;
            iv  = ($urandom % 4) != 0;
            rdy = ($urandom % 8) < (r + 1);
            te  = (c >= te_at) && !((c >= te_at + 20) && (c < te_at + 25));
            step(iv, int'($urandom % 4), te, rdy);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
